mc_cpu: RTL and testbench



---
 rtl/mc_cpu_pkg.sv | 69 ++++++
 rtl/alu.sv | 34 +++
 rtl/alu_control.sv | 31 +++
 rtl/mc_ctrl_fsm.sv | 112 +++++++++++
 rtl/reg_file.sv | 24 ++
 rtl/mc_cpu.sv | 119 +++++++++++
 tb/tb_mc_cpu.sv | 385 ++++++++++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the mc_cpu multi-cycle core: opcodes, funct3 codes,
// FSM states, ALU control codes and the instruction-class decoder.
package mc_cpu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_D    = 3'b011;

  localparam logic [1:0] RES_ALU  = 2'd0;
  localparam logic [1:0] RES_MEM  = 2'd1;
  localparam logic [1:0] RES_LINK = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    ALUOP_ADD, ALUOP_BRANCH, ALUOP_RTYPE, ALUOP_ITYPE
  } alu_op_t;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_ILLEGAL
  } cls_t;

  // mem_f3 selects LW/SW or LD/SD depending on the configured XLEN
  function automatic cls_t decode_class(input logic [6:0] opcode, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [2:0] mem_f3);
    decode_class = CLS_ILLEGAL;
    case (opcode)
      OPC_OP:
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == F3_ADD || f3 == F3_SR)))
          decode_class = CLS_ALU;
      OPC_OP_IMM:
        if (f3 == F3_ADD || f3 == F3_SLT || f3 == F3_XOR || f3 == F3_OR || f3 == F3_AND)
          decode_class = CLS_ALU;
      OPC_LOAD:   if (f3 == mem_f3) decode_class = CLS_LOAD;
      OPC_STORE:  if (f3 == mem_f3) decode_class = CLS_STORE;
      OPC_BRANCH:
        if (f3 == F3_BEQ || f3 == F3_BNE || f3 == F3_BLT || f3 == F3_BGE)
          decode_class = CLS_BRANCH;
      OPC_JAL:    decode_class = CLS_JAL;
      default:    decode_class = CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// XLEN-wide integer ALU; shifts use the low log2(XLEN) bits of b.
module alu
  import mc_cpu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] y
);

  localparam int SW = $clog2(XLEN);
  logic [SW-1:0] shamt;
  assign shamt = b[SW-1:0];

  always_comb begin
    y = '0;
    case (alu_ctrl)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLL:  y = a << shamt;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = $signed(a) >>> shamt;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, a < b};
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/alu_control.sv
// Maps the datapath ALU operation class plus funct3/funct7 to an ALU control code.
module alu_control
  import mc_cpu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_BRANCH: alu_ctrl = funct3[2] ? ALU_SLT : ALU_SUB;
      ALUOP_RTYPE, ALUOP_ITYPE: begin
        case (funct3)
          F3_ADD:  alu_ctrl = (alu_op == ALUOP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          F3_SLL:  alu_ctrl = ALU_SLL;
          F3_SLT:  alu_ctrl = ALU_SLT;
          F3_SLTU: alu_ctrl = ALU_SLTU;
          F3_XOR:  alu_ctrl = ALU_XOR;
          F3_SR:   alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          F3_OR:   alu_ctrl = ALU_OR;
          default: alu_ctrl = ALU_AND;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Sequencing FSM for mc_cpu: memory handshake, retire/halted and datapath enables.
module mc_ctrl_fsm
  import mc_cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_ready,
  input  logic [2:0] cls,
  input  logic       taken,
  input  logic       misaligned,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       retire,
  output logic       halted,
  output logic       ir_we,
  output logic       res_we,
  output logic [1:0] res_sel,
  output logic       pc_we,
  output logic       pc_sel,
  output logic       rf_we
);

  state_t state, state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    retire     = 1'b0;
    halted     = 1'b0;
    ir_we      = 1'b0;
    res_we     = 1'b0;
    res_sel    = RES_ALU;
    pc_we      = 1'b0;
    pc_sel     = 1'b0;
    rf_we      = 1'b0;
    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: state_next = (cls == CLS_ILLEGAL) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (cls)
          CLS_ALU: begin
            res_we     = 1'b1;
            state_next = S_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            res_we     = 1'b1;
            state_next = S_MEM;
          end
          CLS_BRANCH: begin
            if (taken && misaligned) state_next = S_HALT;
            else begin
              pc_we      = 1'b1;
              pc_sel     = taken;
              retire     = 1'b1;
              state_next = S_FETCH;
            end
          end
          CLS_JAL: begin
            if (misaligned) state_next = S_HALT;
            else begin
              res_we     = 1'b1;
              res_sel    = RES_LINK;
              state_next = S_WB;
            end
          end
          default: state_next = S_HALT;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (cls == CLS_STORE);
        if (mem_ready) begin
          if (cls == CLS_STORE) begin
            pc_we      = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end else begin
            res_we     = 1'b1;
            res_sel    = RES_MEM;
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we      = 1'b1;
        pc_we      = 1'b1;
        pc_sel     = (cls == CLS_JAL);
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: rtl/reg_file.sv
// 32-entry integer register file, two combinational reads, one write port; x0 is hardwired zero.
module reg_file #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            we,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [0:31];

  always_ff @(posedge clk) begin
    if (we && wa != 5'd0) regs[wa] <= wd;
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/mc_cpu.sv
// Multi-cycle RV32/RV64 integer core datapath over a single valid/ready memory port.
// Define MC_CPU_INSTRET_EN to add the 64-bit retired-instruction counter output.
module mc_cpu
  import mc_cpu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            retire,
  output logic            halted
`ifdef MC_CPU_INSTRET_EN
  ,
  output logic [63:0]     instret
`endif
);

  localparam logic [2:0] MEM_F3 = (XLEN == 64) ? F3_D : F3_W;

  logic [XLEN-1:0] pc, result, imm, rs1_val, rs2_val, alu_b, alu_y, target, pc_plus4;
  logic [31:0]     ir;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [1:0]      alu_op, res_sel;
  logic [3:0]      alu_ctrl;
  cls_t            cls;
  logic            taken, misaligned, addr_sel, ir_we, res_we, pc_we, pc_sel, rf_we;

  assign opcode   = ir[6:0];
  assign f3       = ir[14:12];
  assign cls      = decode_class(opcode, f3, ir[31:25], MEM_F3);
  assign pc_plus4 = pc + XLEN'(4);
  assign target   = pc + imm;
  assign misaligned = (target[1:0] != 2'b00);

  always_comb begin
    case (opcode)
      OPC_STORE:  imm = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
      OPC_BRANCH: imm = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OPC_JAL:    imm = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:    imm = {{(XLEN-12){ir[31]}}, ir[31:20]};
    endcase
  end

  always_comb begin
    alu_op = ALUOP_ADD;
    if (cls == CLS_ALU)         alu_op = (opcode == OPC_OP) ? ALUOP_RTYPE : ALUOP_ITYPE;
    else if (cls == CLS_BRANCH) alu_op = ALUOP_BRANCH;
  end

  assign alu_b = (opcode == OPC_OP || opcode == OPC_BRANCH) ? rs2_val : imm;

  // BEQ/BNE test the SUB result for zero, BLT/BGE test the SLT result
  always_comb begin
    case (f3)
      F3_BEQ:  taken = (alu_y == '0);
      F3_BNE:  taken = (alu_y != '0);
      F3_BLT:  taken = alu_y[0];
      F3_BGE:  taken = !alu_y[0];
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= RESET_PC;
      ir     <= '0;
      result <= '0;
    end else begin
      if (pc_we)  pc <= pc_sel ? target : pc_plus4;
      if (ir_we)  ir <= mem_rdata[31:0];
      if (res_we) begin
        case (res_sel)
          RES_MEM:  result <= mem_rdata;
          RES_LINK: result <= pc_plus4;
          default:  result <= alu_y;
        endcase
      end
    end
  end

  assign mem_addr  = addr_sel ? result : pc;
  assign mem_wdata = rs2_val;

`ifdef MC_CPU_INSTRET_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instret <= '0;
    else if (retire) instret <= instret + 64'd1;
  end
`endif

  reg_file #(.XLEN(XLEN)) u_rf (
    .clk(clk), .we(rf_we), .ra1(ir[19:15]), .ra2(ir[24:20]), .wa(ir[11:7]),
    .wd(result), .rd1(rs1_val), .rd2(rs2_val)
  );

  alu_control u_aluc (
    .alu_op(alu_op), .funct3(f3), .funct7b5(ir[30]), .alu_ctrl(alu_ctrl)
  );

  alu #(.XLEN(XLEN)) u_alu (
    .a(rs1_val), .b(alu_b), .alu_ctrl(alu_ctrl), .y(alu_y)
  );

  mc_ctrl_fsm u_fsm (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .cls(cls), .taken(taken),
    .misaligned(misaligned), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .retire(retire), .halted(halted), .ir_we(ir_we), .res_we(res_we), .res_sel(res_sel),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we)
  );

endmodule

// File: tb/tb_mc_cpu.sv
// Directed self-checking bench for mc_cpu (XLEN=64, RESET_PC=0x100) with a
// small memory model: instructions at 0x100+, data below 0x100 with optional wait states.
module tb_mc_cpu;

  localparam logic [31:0] NOP      = 32'h00000013;
  localparam logic [31:0] ILLEGAL  = 32'h0000007F;
  localparam logic [31:0] ADDI_1_5 = 32'h00500093;
  localparam logic [31:0] ADDI_2_M3 = 32'hFFD00113;
  localparam logic [31:0] ADD_3_1_2 = 32'h002081B3;
  localparam logic [31:0] SUB_4_2_1 = 32'h40110233;
  localparam logic [31:0] ADDI_3_2 = 32'h00200193;
  localparam logic [31:0] SD_3_8   = 32'h00303423;
  localparam logic [31:0] LD_5_8   = 32'h00803283;
  localparam logic [31:0] BEQ_M8   = 32'hFE108CE3;
  localparam logic [31:0] BNE_M8   = 32'hFE109CE3;
  localparam logic [31:0] JAL_7_P8 = 32'h008003EF;
  localparam logic [31:0] JAL_7_P2 = 32'h002003EF;
  localparam logic [31:0] ADDI_1_7 = 32'h00700093;
  localparam logic [31:0] ADDI_7_9 = 32'h00900393;
  localparam logic [31:0] ADDI_7_1 = 32'h00100393;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MC_CPU_INSTRET_EN
  logic [63:0] instret;
`endif

  logic [63:0] imem [0:63];
  logic [63:0] dmem [0:31];
  logic        data_wait = 1'b0;
  logic        stall = 1'b0;
  logic        is_data;
  int          wait_cnt = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  mc_cpu #(.XLEN(64), .RESET_PC(64'h100)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .retire(retire), .halted(halted)
`ifdef MC_CPU_INSTRET_EN
    , .instret(instret)
`endif
  );

  // Memory model: data accesses may be held off two cycles when data_wait is set
  assign is_data   = mem_addr < 64'h100;
  assign mem_ready = mem_req && !stall && !(data_wait && is_data && wait_cnt < 2);
  assign mem_rdata = is_data ? dmem[mem_addr[7:3]] : imem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (rst || !mem_req || mem_ready) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (!rst && mem_req && mem_ready && mem_we) dmem[mem_addr[7:3]] <= mem_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_imem(input logic [31:0] fill);
    for (int i = 0; i < 64; i++) imem[i] = {32'h0, fill};
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    data_wait = 1'b0;
    stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_access(input logic [63:0] addr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (mem_req && mem_addr == addr) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Steps until the next mem_req, counting cycles and noting any retire on the way
  task automatic steps_to_next_req(output int n, output bit saw_ret);
    n = 0;
    saw_ret = 1'b0;
    while (n < 20) begin
      if (retire) saw_ret = 1'b1;
      step();
      n++;
      if (mem_req) break;
    end
  endtask

  task automatic test_reset();
    clear_imem(NOP);
    rst = 1'b1;
    step();
    vectors++;
    if (mem_req !== 1'b0 || retire !== 1'b0 || halted !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: req/retire/halted=%b%b%b expected 000", mem_req, retire, halted);
    end
`ifdef MC_CPU_INSTRET_EN
    vectors++;
    if (instret !== 64'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_instret: got %0d expected 0", instret);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (mem_req !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_req: got %b expected 0", mem_req);
    end
    step();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h100 || mem_we !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL first_fetch: req=%b addr=%h we=%b expected req=1 addr=100 we=0",
               mem_req, mem_addr, mem_we);
    end
  endtask

  task automatic test_alu();
    int cyc, nret;
    clear_imem(ILLEGAL);
    imem[0] = {32'h0, ADDI_1_5};
    imem[1] = {32'h0, ADDI_2_M3};
    imem[2] = {32'h0, ADD_3_1_2};
    imem[3] = {32'h0, SUB_4_2_1};
    apply_reset();
    step();
    cyc = 1;
    nret = 0;
    forever begin
      if (retire) nret++;
      if (nret >= 4 || cyc >= 100) break;
      step();
      cyc++;
    end
    vectors++;
    if (nret !== 4 || cyc !== 16) begin
      miscompares++;
      $display("[TB] FAIL alu_timing: retires=%0d cycles=%0d expected 4 in 16", nret, cyc);
    end
    step();
    vectors++;
    if (dut.u_rf.regs[3] !== 64'd2) begin
      miscompares++;
      $display("[TB] FAIL alu_add: x3=%h expected 2", dut.u_rf.regs[3]);
    end
    vectors++;
    if (dut.u_rf.regs[4] !== 64'hFFFF_FFFF_FFFF_FFF8) begin
      miscompares++;
      $display("[TB] FAIL alu_sub: x4=%h expected fffffffffffffff8", dut.u_rf.regs[4]);
    end
    vectors++;
    if (dut.u_rf.regs[2] !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      miscompares++;
      $display("[TB] FAIL alu_addi_neg: x2=%h expected fffffffffffffffd", dut.u_rf.regs[2]);
    end
`ifdef MC_CPU_INSTRET_EN
    vectors++;
    if (instret !== 64'd4) begin
      miscompares++;
      $display("[TB] FAIL alu_instret: got %0d expected 4", instret);
    end
`endif
  endtask

  task automatic test_mem();
    bit ok;
    int cyc;
    clear_imem(ILLEGAL);
    imem[0] = {32'h0, ADDI_3_2};
    imem[1] = {32'h0, SD_3_8};
    imem[2] = {32'h0, LD_5_8};
    apply_reset();
    data_wait = 1'b1;
    wait_access(64'h8, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL store_timeout: no access to 0x8 seen expected one");
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (mem_req !== 1'b1 || mem_addr !== 64'h8 || mem_we !== 1'b1 || mem_wdata !== 64'd2) begin
        miscompares++;
        $display("[TB] FAIL store_hold%0d: req=%b addr=%h we=%b wdata=%h expected 1/8/1/2",
                 i, mem_req, mem_addr, mem_we, mem_wdata);
      end
      step();
    end
    vectors++;
    if (dmem[1] !== 64'd2 || mem_req !== 1'b1 || mem_addr !== 64'h108) begin
      miscompares++;
      $display("[TB] FAIL store_done: mem[8]=%h next addr=%h expected 2 and 108", dmem[1], mem_addr);
    end
    cyc = 1;
    while (!retire && cyc < 50) begin
      step();
      cyc++;
      if (mem_req && mem_addr == 64'h8) begin
        vectors++;
        if (mem_we !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL load_we: got %b expected 0", mem_we);
        end
      end
    end
    vectors++;
    if (cyc !== 7) begin
      miscompares++;
      $display("[TB] FAIL load_cycles: got %0d expected 7", cyc);
    end
    step();
    vectors++;
    if (dut.u_rf.regs[5] !== 64'd2) begin
      miscompares++;
      $display("[TB] FAIL load_data: x5=%h expected 2", dut.u_rf.regs[5]);
    end
  endtask

  task automatic test_branch();
    logic [31:0] br   [2];
    logic [63:0] dest [2];
    bit ok, saw_ret;
    int n;
    br[0] = BEQ_M8;  dest[0] = 64'h118;
    br[1] = BNE_M8;  dest[1] = 64'h124;
    for (int k = 0; k < 2; k++) begin
      clear_imem(NOP);
      imem[8] = {32'h0, br[k]};
      apply_reset();
      wait_access(64'h120, ok);
      steps_to_next_req(n, saw_ret);
      vectors++;
      if (!ok || n !== 3 || mem_addr !== dest[k] || !saw_ret) begin
        miscompares++;
        $display("[TB] FAIL branch%0d: found=%b cycles=%0d next=%h retire=%b expected 1/3/%h/1",
                 k, ok, n, mem_addr, saw_ret, dest[k]);
      end
    end
  endtask

  task automatic test_jal();
    bit saw_ret;
    int n;
    clear_imem(ILLEGAL);
    imem[0] = {32'h0, JAL_7_P8};
    apply_reset();
    step();
    steps_to_next_req(n, saw_ret);
    vectors++;
    if (n !== 4 || mem_addr !== 64'h108 || !saw_ret) begin
      miscompares++;
      $display("[TB] FAIL jal_flow: cycles=%0d next=%h retire=%b expected 4/108/1", n, mem_addr, saw_ret);
    end
    vectors++;
    if (dut.u_rf.regs[7] !== 64'h104) begin
      miscompares++;
      $display("[TB] FAIL jal_link: x7=%h expected 104", dut.u_rf.regs[7]);
    end
    repeat (5) step();
    vectors++;
    if (halted !== 1'b1 || mem_req !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL jal_then_halt: halted=%b req=%b expected 1/0", halted, mem_req);
    end
  endtask

  task automatic test_halt();
    int nret, bad;
    logic [31:0] second [2];
    logic [4:0]  reg_idx [2];
    logic [63:0] reg_val [2];
    second[0] = ILLEGAL;   reg_idx[0] = 5'd1; reg_val[0] = 64'd7;
    second[1] = JAL_7_P2;  reg_idx[1] = 5'd7; reg_val[1] = 64'd9;
    for (int k = 0; k < 2; k++) begin
      clear_imem(ADDI_7_1);
      imem[0] = {32'h0, (k == 0) ? ADDI_1_7 : ADDI_7_9};
      imem[1] = {32'h0, second[k]};
      apply_reset();
      nret = 0;
      bad = 0;
      for (int c = 0; c < 30; c++) begin
        step();
        if (retire) nret++;
        if (halted && mem_req) bad++;
      end
      vectors++;
      if (halted !== 1'b1 || mem_req !== 1'b0 || bad !== 0) begin
        miscompares++;
        $display("[TB] FAIL halt%0d_state: halted=%b req=%b req_while_halted=%0d expected 1/0/0",
                 k, halted, mem_req, bad);
      end
      vectors++;
      if (nret !== 1) begin
        miscompares++;
        $display("[TB] FAIL halt%0d_retires: got %0d expected 1", k, nret);
      end
      vectors++;
      if (dut.u_rf.regs[reg_idx[k]] !== reg_val[k] || dut.pc !== 64'h104) begin
        miscompares++;
        $display("[TB] FAIL halt%0d_arch: x%0d=%h pc=%h expected %h and 104",
                 k, reg_idx[k], dut.u_rf.regs[reg_idx[k]], dut.pc, reg_val[k]);
      end
`ifdef MC_CPU_INSTRET_EN
      vectors++;
      if (instret !== 64'd1) begin
        miscompares++;
        $display("[TB] FAIL halt%0d_instret: got %0d expected 1", k, instret);
      end
`endif
    end
  endtask

  task automatic test_back_to_back_reset();
    bit ok;
    clear_imem(NOP);
    apply_reset();
    wait_access(64'h104, ok);
    stall = 1'b1;
    step();
    vectors++;
    if (!ok || mem_req !== 1'b1 || mem_addr !== 64'h104) begin
      miscompares++;
      $display("[TB] FAIL stall_fetch: found=%b req=%b addr=%h expected 1/1/104", ok, mem_req, mem_addr);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (mem_req !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_drop: req=%b expected 0", mem_req);
    end
    stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
`ifdef MC_CPU_INSTRET_EN
    vectors++;
    if (instret !== 64'd0) begin
      miscompares++;
      $display("[TB] FAIL rst_instret: got %0d expected 0", instret);
    end
`endif
    step();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h100) begin
      miscompares++;
      $display("[TB] FAIL refetch: req=%b addr=%h expected 1/100", mem_req, mem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_jal();
    test_halt();
    test_back_to_back_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
